// File: rtl/contador_decresc_4b.sv
// Down counter updated on the falling clock edge, with parallel load, borrow out and terminal-count pulse.
// Define ONESHOT_EN to add the RUN/HALT one-shot FSM along with the ONESHOT and DONE ports.
module contador_decresc_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
`ifdef ONESHOT_EN
  input  logic             ONESHOT,
  output logic             DONE,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             TC
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             hit_q, hit_d;
  logic             tc_q;
  logic             halted;

`ifdef ONESHOT_EN
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  state_t state_q, state_d;
  logic   done_q;

  assign halted = (state_q == HALT);

  always_comb begin
    state_d = state_q;
    if (!ONESHOT) begin
      state_d = RUN;
    end else if (LD) begin
      state_d = (D != '0) ? RUN : state_q;
    end else if (EN && (state_q == RUN) && (q_q == ONE)) begin
      state_d = HALT;
    end
  end

  assign DONE = done_q;
`else
  assign halted = 1'b0;
`endif

  // hit_d flags the 1 -> 0 decrement; TC follows it by one more edge.
  always_comb begin
    q_d   = q_q;
    hit_d = 1'b0;
    if (LD) begin
      q_d = D;
    end else if (EN && !halted) begin
      q_d   = q_q - ONE;
      hit_d = (q_q == ONE);
    end
  end

  always_ff @(negedge clk or negedge CLR) begin
    if (!CLR) begin
      q_q   <= '0;
      hit_q <= 1'b0;
      tc_q  <= 1'b0;
`ifdef ONESHOT_EN
      state_q <= RUN;
      done_q  <= 1'b0;
`endif
    end else begin
      q_q   <= q_d;
      hit_q <= hit_d;
      tc_q  <= hit_q;
`ifdef ONESHOT_EN
      state_q <= state_d;
      done_q  <= (state_d == HALT);
`endif
    end
  end

  assign Q  = q_q;
  assign TC = tc_q;
  assign BO = EN & (q_q == '0) & ~LD & ~halted;

endmodule

// File: doc/contador_decresc_4b.md
CONTADOR_DECRESC_4B -- requirements
Module: contador_decresc_4b

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; legal range 2..8.
REQ-002 Port: clk  input  1  clock; all state updates on the falling edge.
REQ-003 Port: CLR  input  1  reset; asynchronous, active-low.
REQ-004 Port: EN  input  1  count enable, active-high.
REQ-005 Port: LD  input  1  synchronous parallel load, active-high.
REQ-006 Port: D  input  WIDTH  load value.
REQ-007 Port: Q  output  WIDTH  registered count value.
REQ-008 Port: BO  output  1  borrow out, combinational: EN & (Q == 0) & ~LD.
REQ-009 Port: TC  output  1  registered terminal-count pulse.
REQ-010 Port: ONESHOT  input  1  mode select; present only with ONESHOT_EN.
REQ-011 Port: DONE  output  1  registered halt flag; present only with ONESHOT_EN.

Function
REQ-012 The counter SHALL be fully synchronous, with no rippled clocks; every flop SHALL share clk.
REQ-013 Priority per falling edge SHALL be: LD, then EN, then hold.
REQ-014 LD=1: Q <= D on that edge, regardless of EN.
REQ-015 LD=0, EN=1: Q <= Q-1, modulo 2^WIDTH.
REQ-016 Q=0 with EN=1 SHALL wrap to 2^WIDTH-1 (all ones) in free-run mode.
REQ-017 LD=0, EN=0: Q holds.
REQ-018 TC SHALL be 1 for exactly one cycle, on the edge after the edge where Q went 1 -> 0 by decrement.
REQ-019 TC SHALL be 0 when Q reaches 0 by load, and 0 whenever Q is held at 0.
REQ-020 BO SHALL allow cascading: the BO of the lower stage drives the EN of the upper stage, and both stages share clk.
REQ-021 Latency SHALL be 1 edge from LD or EN sampling to the updated Q.
REQ-022 Q, TC and DONE SHALL be glitch-free registered outputs; BO is the only combinational output.

Reset
REQ-023 CLR=0 SHALL immediately force Q=0, TC=0 and DONE=0, independent of clk.
REQ-024 While CLR=0, LD and EN SHALL be ignored.
REQ-025 After CLR rises, the first falling edge SHALL operate normally.
REQ-026 A reset asserted mid-count SHALL abort the count; no TC pulse results from it.

Configuration
REQ-027 Macro ONESHOT_EN SHALL compile in the two-state FSM {RUN, HALT} together with the ONESHOT and DONE ports.
REQ-028 With ONESHOT_EN defined and ONESHOT=1:
- in RUN, decrementing from 1 to 0 moves the FSM to HALT and sets DONE=1 on the same edge;
- in HALT, EN is ignored, Q stays 0 and no wrap occurs;
- LD=1 with D != 0 returns the FSM to RUN and clears DONE;
- LD=1 with D == 0 keeps the FSM in HALT.
REQ-029 With ONESHOT_EN defined and ONESHOT=0, the FSM SHALL stay in RUN and DONE SHALL stay 0 (free-run behaviour).
REQ-030 With ONESHOT_EN defined, BO SHALL be 0 in HALT.
REQ-031 Without ONESHOT_EN, the ONESHOT and DONE ports and the FSM SHALL be absent, and the block SHALL always free-run.
REQ-032 TC behaviour SHALL be identical with and without ONESHOT_EN.

Verification
REQ-033 Reset then EN=1 for 17 edges -> Q = 0, 15, 14, ..., 0, 15; one TC pulse, after the 1 -> 0 step.
REQ-034 LD=1 with D=9 and EN=1 on the same edge -> Q=9, not 8; next edge Q=8.
REQ-035 CLR pulsed low between edges at Q=6 -> Q=0 immediately, TC=0; counting resumes on the next edge.
REQ-036 Two instances cascaded (BO -> EN), clocked 256 edges from 0 -> combined value steps 0, 255, 254, ... and wraps correctly.
REQ-037 ONESHOT_EN, ONESHOT=1, load 3, EN=1 -> Q = 3, 2, 1, 0, 0, ...; DONE=1 from the edge reaching 0; then load 5 -> DONE=0.
REQ-038 EN=0 with Q=0 for 4 edges -> Q stays 0, TC=0, BO=0.
